// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary to packed-BCD converter with start/ready/done handshake.
// The result register only changes on the done edge, so a downstream display never sees partial values.
module bin_to_bcd_converter #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  function automatic longint unsigned pow10_minus1(input int d);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p - 1;
  endfunction

  localparam longint unsigned LIMIT = pow10_minus1(DIGITS);
  localparam int LIM_W = $clog2(LIMIT + 1);
  localparam int CMP_W = (WIDTH > LIM_W) ? WIDTH : LIM_W;
  localparam logic [CMP_W-1:0] LIMIT_C = CMP_W'(LIMIT);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   shreg, shreg_n;
  logic [WIDTH-1:0]   operand, operand_n;
  logic [BW-1:0]      scratch, scratch_n, adj;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [BW-1:0]      bcd_n;
  logic               ovf_n, done_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      shreg    <= '0;
      operand  <= '0;
      scratch  <= '0;
      cnt      <= '0;
      bcd      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      operand  <= operand_n;
      scratch  <= scratch_n;
      cnt      <= cnt_n;
      bcd      <= bcd_n;
      overflow <= ovf_n;
      done     <= done_n;
    end
  end

  // Add-3 correction on every digit that would reach 10 or more after doubling.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    operand_n = operand;
    scratch_n = scratch;
    cnt_n     = cnt;
    bcd_n     = bcd;
    ovf_n     = overflow;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          shreg_n   = bin;
          operand_n = bin;
          scratch_n = '0;
          cnt_n     = CNT_W'(WIDTH);
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_n, shreg_n} = {adj, shreg} << 1;
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = FINISH;
      end
      FINISH: begin
        done_n  = 1'b1;
        state_n = IDLE;
        // Top-digit carries are lost in the scratch, so saturate from the latched operand.
        if (CMP_W'(operand) > LIMIT_C) begin
          bcd_n = {DIGITS{4'h9}};
          ovf_n = 1'b1;
        end else begin
          bcd_n = scratch;
          ovf_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign busy  = ~ready;

endmodule
